// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcode constants and
// operation enums used by the fetch stage and its decoder.
package cpu_pkg;

  localparam int PC_W_DEF = 8;
  localparam int IW_DEF   = 16;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Instruction word field positions (inclusive bit ranges)
  localparam int OPC_HI = 15, OPC_LO = 13;
  localparam int ALU_HI = 12, ALU_LO = 11;
  localparam int RN_HI  = 10, RN_LO  = 8;
  localparam int RD_HI  = 7,  RD_LO  = 5;
  localparam int SH_HI  = 4,  SH_LO  = 3;
  localparam int RM_HI  = 2,  RM_LO  = 0;
  localparam int IMM8_W = 8;
  localparam int IMM5_W = 5;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_CMP = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

endpackage

// File: rtl/fetch_unit_if.sv
// RAM-side bus of the fetch stage: address, write data/enable, read data.
interface fetch_unit_if #(
  parameter int PC_W = 8,
  parameter int IW   = 16
);
  logic [PC_W-1:0] mem_addr;
  logic [IW-1:0]   mem_wdata;
  logic            mem_w_en;
  logic [IW-1:0]   mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_w_en, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_w_en, output mem_rdata);
endinterface

// File: rtl/fetch_unit_decoder.sv
// Combinational instruction decoder: field slices and sign-extended
// immediates taken straight from the registered instruction word.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic [IW-1:0] ir,
  output logic [2:0]    opcode,
  output logic [1:0]    ALU_op,
  output logic [1:0]    shift_op,
  output logic [2:0]    rn,
  output logic [2:0]    rd,
  output logic [2:0]    rm,
  output logic [IW-1:0] sximm8,
  output logic [IW-1:0] sximm5
);
  alu_op_e   alu_f;
  shift_op_e sh_f;

  assign alu_f    = alu_op_e'(ir[ALU_HI:ALU_LO]);
  assign sh_f     = shift_op_e'(ir[SH_HI:SH_LO]);
  assign opcode   = ir[OPC_HI:OPC_LO];
  assign ALU_op   = alu_f;
  assign shift_op = sh_f;
  assign rn       = ir[RN_HI:RN_LO];
  assign rd       = ir[RD_HI:RD_LO];
  assign rm       = ir[RM_HI:RM_LO];
  assign sximm8   = {{(IW-IMM8_W){ir[IMM8_W-1]}}, ir[IMM8_W-1:0]};
  assign sximm5   = {{(IW-IMM5_W){ir[IMM5_W-1]}}, ir[IMM5_W-1:0]};
endmodule

// File: rtl/fetch_unit.sv
// Fetch / memory-address stage: PC, data address register and IR, RAM address
// mux and decode. Define FETCH_COUNT_EN to add the fetch_count output.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int IW   = IW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_pc,
  input  logic            clear_pc,
  input  logic            load_addr,
  input  logic            load_ir,
  input  logic            sel_addr,
  input  logic            ram_w_en,
  input  logic [IW-1:0]   datapath_out,
  fetch_unit_if.master    bus,
  output logic [PC_W-1:0] pc,
  output logic [IW-1:0]   ir,
  output logic            ir_valid,
  output logic            pc_wrapped,
  output logic [2:0]      opcode,
  output logic [1:0]      ALU_op,
  output logic [1:0]      shift_op,
  output logic [2:0]      rn,
  output logic [2:0]      rd,
  output logic [2:0]      rm,
  output logic [IW-1:0]   sximm8,
  output logic [IW-1:0]   sximm5
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]     fetch_count
`endif
);
  logic [PC_W-1:0] dar;
  logic            pc_clear;

  assign pc_clear = load_pc & clear_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      pc_wrapped <= 1'b0;
    end else if (pc_clear) begin
      pc         <= '0;
      pc_wrapped <= 1'b0;
    end else if (load_pc) begin
      pc <= pc + PC_W'(1);
      if (&pc) pc_wrapped <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         dar <= '0;
    else if (load_addr) dar <= datapath_out[PC_W-1:0];
  end

  // ir captures even during a clear; only the valid flag is killed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else begin
      if (load_ir) ir <= bus.mem_rdata;
      if (pc_clear)     ir_valid <= 1'b0;
      else if (load_ir) ir_valid <= 1'b1;
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        fetch_count <= '0;
    else if (pc_clear) fetch_count <= '0;
    else if (load_ir)  fetch_count <= fetch_count + 16'd1;
  end
`endif

  // Writes are suppressed whenever the fetch address is selected
  assign bus.mem_addr  = sel_addr ? pc : dar;
  assign bus.mem_wdata = datapath_out;
  assign bus.mem_w_en  = ram_w_en & ~sel_addr;

  instr_decoder #(.IW(IW)) u_dec (
    .ir       (ir),
    .opcode   (opcode),
    .ALU_op   (ALU_op),
    .shift_op (shift_op),
    .rn       (rn),
    .rd       (rd),
    .rm       (rm),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and memory-address stage that sits downstream of the CPU controller.
- Owns the program counter (PC), the data address register (DAR) and the instruction register (IR).
- Drives the RAM address port and decodes the IR into the opcode and operand fields the controller and datapath consume.
- Acts only on the controller strobes load_pc, clear_pc, load_addr, load_ir, sel_addr and ram_w_en.

Parameters:
- PC_W, 8, width of PC, DAR and the RAM address.
- IW, 16, instruction and data word width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_pc  in  1  PC update strobe.
- clear_pc  in  1  with load_pc, selects PC <= 0.
- load_addr  in  1  DAR load strobe.
- load_ir  in  1  IR load strobe.
- sel_addr  in  1  address select: 1 = PC, 0 = DAR.
- ram_w_en  in  1  controller RAM write request.
- datapath_out  in  IW  datapath C result; DAR source and write data.
- mem_rdata  in  IW  RAM read data.
- mem_addr  out  PC_W  RAM address.
- mem_wdata  out  IW  RAM write data.
- mem_w_en  out  1  RAM write enable.
- pc  out  PC_W  current PC.
- ir  out  IW  current instruction.
- ir_valid  out  1  IR holds a fetched word.
- pc_wrapped  out  1  sticky PC-overflow flag.
- opcode  out  3  ir[15:13].
- ALU_op  out  2  ir[12:11].
- shift_op  out  2  ir[4:3].
- rn  out  3  ir[10:8].
- rd  out  3  ir[7:5].
- rm  out  3  ir[2:0].
- sximm8  out  IW  ir[7:0] sign-extended.
- sximm5  out  IW  ir[4:0] sign-extended.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=0, DAR=0, ir=0, ir_valid=0, pc_wrapped=0.
  - Combinational outputs follow from these reset values.
- PC update, per cycle:
  - load_pc=1 and clear_pc=1: pc <= 0, pc_wrapped <= 0, ir_valid <= 0.
  - load_pc=1 and clear_pc=0: pc <= pc+1, modulo 2^PC_W.
  - The increment from 2^PC_W-1 (255) to 0 sets pc_wrapped=1. The flag holds until reset or a clear.
  - clear_pc=1 with load_pc=0: ignored, no state change.
  - load_pc=0: pc holds.
- DAR: load_addr=1 gives DAR <= datapath_out[PC_W-1:0]; upper bits are discarded. Otherwise DAR holds.
- IR: load_ir=1 gives ir <= mem_rdata and ir_valid <= 1. Otherwise ir holds.
- Strobe priority:
  - If load_ir and a load_pc+clear_pc clear coincide, the clear wins for ir_valid (0).
  - ir still captures mem_rdata in that cycle.
  - All other strobes are independent and may coincide.
  - Each strobe samples pre-edge values: load_ir with load_pc captures the word at the old PC.
- Address path, combinational, zero latency:
  - mem_addr = sel_addr ? pc : DAR.
  - mem_wdata = datapath_out.
  - mem_w_en = ram_w_en & ~sel_addr. A write is never issued to the fetch address.
- Decode fields are pure combinational slices of the registered ir. They are valid the cycle after load_ir.
- Read latency: the RAM is synchronous with 1-cycle read. The controller must hold the address one cycle before load_ir. This block adds no wait states.
- Reset mid-operation: all registers clear immediately; no partial update survives.

Optional Feature:
- Macro FETCH_COUNT_EN.
- When defined:
  - Adds output fetch_count [15:0].
  - Increments on each load_ir, wrapping 0xFFFF to 0.
  - Cleared by rst_n and by load_pc+clear_pc.
  - If load_ir coincides with a clear, the count becomes 0.
- When undefined: port absent, no counter logic.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants: MOV=3'b110, ALU=3'b101.
  - ALU_op and shift_op enums.
  - PC_W and IW defaults.
  - Field bit positions of the instruction word.
- One natural sub-module, instr_decoder: combinational field extraction and sign extension from ir. All registers stay in fetch_unit.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → pc=0, ir=0, ir_valid=0, pc_wrapped=0 immediately, without waiting for a clock edge.
- Clear then fetch:
  - load_pc=1, clear_pc=1 → pc=0.
  - sel_addr=1, mem_rdata=16'hD105, load_ir=1 → ir=D105, ir_valid=1, opcode=3'b110, rn=3'b001, sximm8=16'h0005.
- Increment and wrap:
  - Preload pc=8'hFE, pulse load_pc twice → pc=FF, then 00, pc_wrapped=1.
  - Then load_pc+clear_pc → pc_wrapped=0.
- DAR path:
  - datapath_out=16'h1234, load_addr=1, then sel_addr=0 → mem_addr=8'h34.
  - ram_w_en=1 → mem_w_en=1, mem_wdata=1234.
  - sel_addr=1 with ram_w_en=1 → mem_w_en=0.
- Sign extension: ir=16'hA01F → sximm5=16'hFFFF, sximm8=16'h001F, shift_op=2'b11, rm=3'b111.
- Collisions:
  - load_ir with load_pc+clear_pc → ir captures mem_rdata, ir_valid=0, pc=0.
  - With FETCH_COUNT_EN, fetch_count=0 after 3 prior fetches.
